io_port_device: RTL and testbench
=================================

IO_PORT_DEVICE -- requirements
Module: io_port_device

Interface
REQ-001 Parameter W, default 16, data width of the processor I/O ports.
REQ-002 Parameter DEPTH, default 4, entries per FIFO; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 dev_in_data  input  W  word offered by the external producer.
REQ-006 dev_in_valid  input  1  producer offers dev_in_data this cycle.
REQ-007 dev_in_ready  output  1  device accepts dev_in_data this cycle; equals not-full.
REQ-008 in_port  output  W  head of input FIFO, presented to the processor in_port.
REQ-009 in_rd  input  1  processor consumes in_port this cycle (IN instruction strobe).
REQ-010 interrupt  output  1  interrupt request to the processor interrupt input.
REQ-011 out_port  input  W  word driven by the processor out_port.
REQ-012 out_wr  input  1  processor writes out_port this cycle (OUT instruction strobe).
REQ-013 dev_out_data  output  W  head of output FIFO, offered to the external consumer.
REQ-014 dev_out_valid  output  1  dev_out_data is valid; equals output-FIFO not-empty.
REQ-015 dev_out_ready  input  1  consumer takes dev_out_data this cycle.
REQ-016 in_overrun  output  1  sticky: an in_rd arrived while the input FIFO was empty.
REQ-017 out_overflow  output  1  sticky: an out_wr was dropped because the output FIFO was full.

Function
REQ-018 Input push occurs when dev_in_valid and dev_in_ready are both high; output pop occurs when dev_out_valid and dev_out_ready are both high.
REQ-019 Input pop occurs on in_rd with the input FIFO non-empty; output push occurs on out_wr with the output FIFO non-full, or with the FIFO full and a pop in the same cycle.
REQ-020 dev_in_ready is low when the input FIFO is full, even if in_rd is high in the same cycle (registered full; no combinational path from in_rd to dev_in_ready).
REQ-021 in_port shows the head entry combinationally from FIFO state and is 0 when the input FIFO is empty.
REQ-022 Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty are derived from MSB and index comparison.
REQ-023 A push and a pop in the same cycle on a non-empty FIFO leave the count unchanged and preserve data order.
REQ-024 Write-to-visibility latency is 1 cycle: a word pushed at edge N appears on in_port or dev_out_data after edge N.
REQ-025 The interrupt FSM has three states, each lasting the stated time:
- IDLE: interrupt=0; go to PULSE when the input FIFO is non-empty.
- PULSE: interrupt=1 for exactly one cycle; then go to WAIT.
- WAIT: interrupt=0; go to IDLE on an accepted input pop.
REQ-026 After a pop returns the FSM to IDLE, a still non-empty FIFO produces a new PULSE two cycles after that pop edge (one pulse per word).
REQ-027 An in_rd during PULSE is accepted as a pop; the FSM still passes through WAIT and returns to IDLE on the next edge.
REQ-028 in_overrun and out_overflow set on their event, stay high until reset, and never block FIFO operation.
REQ-029 An in_rd on an empty input FIFO changes no pointers.

Reset
REQ-030 Asserting rst clears both FIFOs' pointers and both sticky flags, and sets the FSM to IDLE, regardless of clk.
REQ-031 While rst is high: dev_in_ready=0, in_port=0, interrupt=0, dev_out_valid=0, dev_out_data=0, in_overrun=0, out_overflow=0.
REQ-032 FIFO storage contents are not reset; outputs are masked by the empty flags.
REQ-033 Reset in the middle of a PULSE ends the pulse immediately; no pulse follows reset release until a new push.

Structure
REQ-034 The shared package holds W, DEPTH, the FSM state encoding and pointer-width constants.
REQ-035 One sub-module, sync_fifo (parameters W and DEPTH), is instantiated twice, once for the input path and once for the output path; the FSM and sticky flags live in io_port_device.

Verification
REQ-036 Push 0x1234 with no in_rd -> interrupt high for exactly 1 cycle, 2 edges after push; in_port=0x1234; no further pulse.
REQ-037 Push 4 words 0xA0..0xA3 -> dev_in_ready=0; a 5th offer is not accepted; 4 in_rd strobes return 0xA0..0xA3 in order, with 4 pulses.
REQ-038 in_rd on an empty input FIFO -> in_port=0, pointers unchanged, in_overrun=1 and held.
REQ-039 5 out_wr strobes of 0xB0..0xB4 with dev_out_ready=0 -> 0xB4 dropped, out_overflow=1; draining yields 0xB0..0xB3.
REQ-040 Output FIFO full, out_wr=0xC0 and dev_out_ready=1 in the same cycle -> head popped, 0xC0 stored, out_overflow stays 0.
REQ-041 Assert rst during a PULSE with 2 words queued -> interrupt drops asynchronously, dev_out_valid=0, in_port=0; no pulse after release.

Source files
------------

// File: rtl/io_port_device_pkg.sv
// Shared constants and types for the processor I/O port device.
// Holds default widths/depths, pointer-width helper and interrupt FSM encoding.
// No logic; imported by sync_fifo and io_port_device.
package io_port_device_pkg;

  // Default processor port width and FIFO depth (depth must be a power of two, >= 2)
  localparam int IOP_W     = 16;
  localparam int IOP_DEPTH = 4;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int IOP_PTR_W = ptr_w(IOP_DEPTH);
  localparam int IOP_IDX_W = IOP_PTR_W - 1;

  // Interrupt request sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with wrap-bit pointers and a zero-masked head output.
// Latency: a word pushed at edge N is visible on o_head_dat after edge N.
// Backpressure: push accepted when not full, or when full with a same-cycle pop; pop ignored when empty.
module sync_fifo
  import io_port_device_pkg::*;
#(
  parameter int W     = IOP_W,
  parameter int DEPTH = IOP_DEPTH
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic          w_full;
  logic          w_empty;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Same index with differing wrap bits means the writer lapped the reader
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) && (w_wr_idx == w_rd_idx);

  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Storage is never reset; the empty flag masks stale contents on the head output
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= i_push_dat;
    end
  end

  // Pointer advance; both wrap naturally modulo 2*DEPTH
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  assign o_head_dat = w_empty ? '0 : r_mem[w_rd_idx];
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule

// File: rtl/io_port_device.sv
// Purpose: bridges an external valid/ready stream pair to processor in_port/out_port with an interrupt per word.
// Latency: one cycle from accepted write to visibility on in_port / dev_out_data; interrupt pulses one cycle after the input FIFO turns non-empty.
// Backpressure: dev_in_ready is registered not-full (no path from in_rd); out_wr on a full, non-draining output FIFO is dropped and flagged.
module io_port_device
  import io_port_device_pkg::*;
#(
  parameter int W     = IOP_W,
  parameter int DEPTH = IOP_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] dev_in_data,
  input  logic         dev_in_valid,
  output logic         dev_in_ready,
  output logic [W-1:0] in_port,
  input  logic         in_rd,
  output logic         interrupt,
  input  logic [W-1:0] out_port,
  input  logic         out_wr,
  output logic [W-1:0] dev_out_data,
  output logic         dev_out_valid,
  input  logic         dev_out_ready,
  output logic         in_overrun,
  output logic         out_overflow
);

  logic         w_in_full;
  logic         w_in_empty;
  logic [W-1:0] w_in_head;
  logic         w_in_push;
  logic         w_in_pop;

  logic         w_out_full;
  logic         w_out_empty;
  logic [W-1:0] w_out_head;
  logic         w_out_push;
  logic         w_out_pop;

  irq_state_t   r_state;
  logic         r_interrupt;
  logic         r_pulse_ack;
  logic         r_in_overrun;
  logic         r_out_overflow;

  // Input path: external producer -> processor in_port
  assign dev_in_ready = !w_in_full && !rst;
  assign w_in_push    = dev_in_valid && dev_in_ready;
  assign w_in_pop     = in_rd && !w_in_empty;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (w_in_push),
    .i_push_dat (dev_in_data),
    .i_pop      (in_rd),
    .o_head_dat (w_in_head),
    .o_full     (w_in_full),
    .o_empty    (w_in_empty)
  );

  assign in_port = w_in_head;

  // Output path: processor out_port -> external consumer
  assign dev_out_valid = !w_out_empty;
  assign w_out_pop     = dev_out_valid && dev_out_ready;
  assign w_out_push    = out_wr && (!w_out_full || w_out_pop);

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_push     (out_wr),
    .i_push_dat (out_port),
    .i_pop      (w_out_pop),
    .o_head_dat (w_out_head),
    .o_full     (w_out_full),
    .o_empty    (w_out_empty)
  );

  assign dev_out_data = w_out_head;

  // Interrupt sequencer: one registered pulse per queued word, re-armed by the processor's IN.
  // A read taken during the pulse itself is remembered so WAIT does not stall for a second read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_interrupt <= 1'b0;
      r_pulse_ack <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_pulse_ack <= 1'b0;
          if (!w_in_empty) begin
            r_state     <= ST_PULSE;
            r_interrupt <= 1'b1;
          end
        end
        ST_PULSE: begin
          r_state     <= ST_WAIT;
          r_interrupt <= 1'b0;
          r_pulse_ack <= w_in_pop;
        end
        ST_WAIT: begin
          if (w_in_pop || r_pulse_ack) begin
            r_state     <= ST_IDLE;
            r_pulse_ack <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_interrupt <= 1'b0;
          r_pulse_ack <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt = r_interrupt;

  // Sticky error flags; they only report and never gate FIFO traffic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_overrun   <= 1'b0;
      r_out_overflow <= 1'b0;
    end else begin
      if (in_rd && w_in_empty)   r_in_overrun   <= 1'b1;
      if (out_wr && !w_out_push) r_out_overflow <= 1'b1;
    end
  end

  assign in_overrun   = r_in_overrun;
  assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_io_port_device.sv
module tb_io_port_device;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] dev_in_data;
  logic         dev_in_valid;
  logic         dev_in_ready;
  logic [W-1:0] in_port;
  logic         in_rd;
  logic         interrupt;
  logic [W-1:0] out_port;
  logic         out_wr;
  logic [W-1:0] dev_out_data;
  logic         dev_out_valid;
  logic         dev_out_ready;
  logic         in_overrun;
  logic         out_overflow;

  always #5 clk = ~clk;

  io_port_device #(.W(W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready),
    .in_port       (in_port),
    .in_rd         (in_rd),
    .interrupt     (interrupt),
    .out_port      (out_port),
    .out_wr        (out_wr),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .in_overrun    (in_overrun),
    .out_overflow  (out_overflow)
  );

  int n_chk   = 0;
  int n_fail  = 0;
  int n_pulse = 0;

  // Reference model: plain queues of words in flight plus the two sticky flags
  logic [W-1:0] in_q[$];
  logic [W-1:0] out_q[$];
  logic         exp_ovr  = 1'b0;
  logic         exp_ofl  = 1'b0;
  logic         prev_int = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard/monitor: mid-cycle, check DUT outputs against the model, then apply
  // the transfers that the current inputs will cause at the next rising edge.
  always @(negedge clk) begin : scoreboard
    logic in_full;
    logic out_full;
    logic out_pop;
    if (rst) begin
      in_q.delete();
      out_q.delete();
      exp_ovr  = 1'b0;
      exp_ofl  = 1'b0;
      prev_int = 1'b0;
      chk("rst_in_ready", dev_in_ready, 0);
      chk("rst_in_port", in_port, 0);
      chk("rst_interrupt", interrupt, 0);
      chk("rst_out_valid", dev_out_valid, 0);
      chk("rst_out_data", dev_out_data, 0);
      chk("rst_overrun", in_overrun, 0);
      chk("rst_overflow", out_overflow, 0);
    end else begin
      in_full  = (in_q.size() >= DEPTH);
      out_full = (out_q.size() >= DEPTH);
      chk("in_ready", dev_in_ready, !in_full);
      chk("in_port", in_port, (in_q.size() > 0) ? in_q[0] : '0);
      chk("out_valid", dev_out_valid, out_q.size() > 0);
      chk("out_data", dev_out_data, (out_q.size() > 0) ? out_q[0] : '0);
      chk("overrun", in_overrun, exp_ovr);
      chk("overflow", out_overflow, exp_ofl);
      chk("int_single_cycle", interrupt && prev_int, 0);
      if (interrupt && !prev_int) n_pulse++;
      prev_int = interrupt;

      if (in_rd) begin
        if (in_q.size() > 0) chk("in_rd_data", in_port, in_q.pop_front());
        else exp_ovr = 1'b1;
      end
      if (dev_in_valid && !in_full) in_q.push_back(dev_in_data);

      out_pop = dev_out_ready && (out_q.size() > 0);
      if (out_pop) chk("out_pop_data", dev_out_data, out_q.pop_front());
      if (out_wr) begin
        if (!out_full || out_pop) out_q.push_back(out_port);
        else exp_ofl = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    dev_in_valid  = 1'b0;
    in_rd         = 1'b0;
    out_wr        = 1'b0;
    dev_out_ready = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      cyc();
      if (interrupt) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int p0;
    idle_all();
    dev_in_data = '0;
    out_port    = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc();

    // Single push, no read: one pulse, two edges counting the push edge
    dev_in_valid = 1'b1; dev_in_data = 16'h1234;
    cyc();
    dev_in_valid = 1'b0;
    chk("t1_int_at_push", interrupt, 0);
    chk("t1_in_port", in_port, 16'h1234);
    cyc();
    chk("t1_pulse", interrupt, 1);
    cyc();
    chk("t1_pulse_end", interrupt, 0);
    p0 = n_pulse;
    repeat (5) cyc();
    chk("t1_no_repulse", n_pulse - p0, 0);
    in_rd = 1'b1; cyc(); in_rd = 1'b0;
    repeat (3) cyc();

    // Fill input FIFO, reject a fifth offer, read back in order with one pulse per word
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      dev_in_valid = 1'b1; dev_in_data = W'(32'hA0 + i);
      cyc();
    end
    dev_in_data = 16'h00FF;
    chk("t2_full_ready", dev_in_ready, 0);
    cyc();
    dev_in_valid = 1'b0;
    chk("t2_head_kept", in_port, 16'h00A0);
    for (int i = 0; i < 4; i++) begin
      in_rd = 1'b1; cyc(); in_rd = 1'b0;
      if (i < 3) begin
        wait_pulse("t2_pulse");
        cyc();
      end
    end
    repeat (4) cyc();
    chk("t2_pulse_count", n_pulse - p0, 4);

    // Read on empty: sticky overrun, data path undisturbed
    chk("t3_in_port_empty", in_port, 0);
    in_rd = 1'b1; cyc(); in_rd = 1'b0;
    chk("t3_overrun", in_overrun, 1);
    chk("t3_in_port", in_port, 0);
    repeat (3) cyc();
    chk("t3_overrun_held", in_overrun, 1);
    dev_in_valid = 1'b1; dev_in_data = 16'h5A5A; cyc(); dev_in_valid = 1'b0;
    chk("t3_after_push", in_port, 16'h5A5A);
    repeat (2) cyc();
    in_rd = 1'b1; cyc(); in_rd = 1'b0;
    chk("t3_empty_again", in_port, 0);

    // Output full with simultaneous pop: write accepted, no overflow
    for (int i = 0; i < 4; i++) begin
      out_wr = 1'b1; out_port = W'(32'h10 + i);
      cyc();
    end
    chk("t4_full", dev_out_valid, 1);
    out_port = 16'h00C0; dev_out_ready = 1'b1;
    cyc();
    out_wr = 1'b0; dev_out_ready = 1'b0;
    chk("t4_head", dev_out_data, 16'h0011);
    chk("t4_no_overflow", out_overflow, 0);
    dev_out_ready = 1'b1; repeat (5) cyc(); dev_out_ready = 1'b0;
    chk("t4_drained", dev_out_valid, 0);

    // Five writes into a stalled consumer: last dropped, overflow sticky
    for (int i = 0; i < 5; i++) begin
      out_wr = 1'b1; out_port = W'(32'hB0 + i);
      cyc();
    end
    out_wr = 1'b0;
    chk("t5_overflow", out_overflow, 1);
    chk("t5_head", dev_out_data, 16'h00B0);
    dev_out_ready = 1'b1; repeat (5) cyc(); dev_out_ready = 1'b0;
    chk("t5_drained", dev_out_valid, 0);
    chk("t5_overflow_held", out_overflow, 1);

    // Reset during a pulse with two words queued
    out_wr = 1'b1; out_port = 16'h0077;
    dev_in_valid = 1'b1; dev_in_data = 16'h0001;
    cyc();
    out_wr = 1'b0; dev_in_data = 16'h0002;
    cyc();
    dev_in_valid = 1'b0;
    chk("t6_pulse", interrupt, 1);
    chk("t6_out_valid_pre", dev_out_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_int_async", interrupt, 0);
    chk("t6_out_valid", dev_out_valid, 0);
    chk("t6_in_port", in_port, 0);
    chk("t6_in_ready", dev_in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    p0 = n_pulse;
    repeat (6) cyc();
    chk("t6_no_pulse_after_rst", n_pulse - p0, 0);

    // Randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      dev_in_valid  = 1'($urandom_range(0, 1));
      dev_in_data   = W'($urandom);
      in_rd         = ($urandom_range(0, 3) == 0);
      out_wr        = 1'($urandom_range(0, 1));
      out_port      = W'($urandom);
      dev_out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    idle_all();
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
